// File: rtl/breakout_pkg.sv
// Shared game types and key constants for the breakout controller, HUD and colour mapper.
package breakout_pkg;

  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    SERVE = 3'd1,
    PLAY  = 3'd2,
    MISS  = 3'd3,
    OVER  = 3'd4,
    WIN   = 3'd5
  } game_state_t;

  localparam logic [7:0] KEY_LAUNCH  = 8'h2C;
  localparam logic [7:0] KEY_RESTART = 8'h15;

endpackage

// File: rtl/breakout_game_ctrl_frame_timer.sv
// Loadable 8-bit frame down-counter; holds at zero and flags it.
module frame_timer (
  input  logic       clk_i,
  input  logic       rst_ni,
  input  logic       load_i,
  input  logic [7:0] load_val_i,
  input  logic       en_i,
  output logic       zero_o
);

  logic [7:0] cnt_q;

  always_ff @(posedge clk_i) begin
    if (!rst_ni) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (en_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 8'd1;
    end
  end

  assign zero_o = (cnt_q == '0);

endmodule

// File: rtl/breakout_game_ctrl.sv
// Per-frame game sequencer: serve/play/miss flow, lives, saturating score and win/game-over.
module breakout_game_ctrl
  import breakout_pkg::*;
#(
  parameter int unsigned LIVES_INIT  = 3,
  parameter int unsigned SERVE_DELAY = 60,
  parameter int unsigned MISS_HOLD   = 90,
  parameter int unsigned Y_FLOOR     = 479,
  parameter int unsigned PTS_BRICK   = 10,
  parameter logic [7:0]  KEY_LAUNCH  = breakout_pkg::KEY_LAUNCH,
  parameter logic [7:0]  KEY_RESTART = breakout_pkg::KEY_RESTART
) (
  input  logic        frame_clk,
  input  logic        Reset_n,
  input  logic [7:0]  keycode,
  input  logic [9:0]  BallY,
  input  logic [9:0]  BallS,
  input  logic        brick_hit,
  input  logic [6:0]  bricks_left,
  output logic        ball_hold,
  output logic        ball_run,
  output logic [1:0]  lives,
  output logic [15:0] score,
  output logic [2:0]  game_state
);

  game_state_t state_q, state_d;
  logic [1:0]  lives_q, lives_d;
  logic [15:0] score_q, score_d;
  logic [7:0]  key_prev_q;

  logic        tmr_load;
  logic [7:0]  tmr_load_val;
  logic        tmr_en;
  logic        tmr_zero;

  logic        launch;
  logic        restart;
  logic        miss;
  logic [10:0] ball_bottom;
  logic [16:0] score_sum;

  frame_timer u_timer (
    .clk_i      (frame_clk),
    .rst_ni     (Reset_n),
    .load_i     (tmr_load),
    .load_val_i (tmr_load_val),
    .en_i       (tmr_en),
    .zero_o     (tmr_zero)
  );

  assign launch      = (keycode == KEY_LAUNCH)  && (key_prev_q != KEY_LAUNCH);
  assign restart     = (keycode == KEY_RESTART) && (key_prev_q != KEY_RESTART);
  assign ball_bottom = {1'b0, BallY} + {1'b0, BallS};
  assign miss        = (ball_bottom >= 11'(Y_FLOOR));
  assign score_sum   = {1'b0, score_q} + 17'(PTS_BRICK);

  always_ff @(posedge frame_clk) begin
    if (!Reset_n) begin
      state_q    <= IDLE;
      lives_q    <= 2'(LIVES_INIT);
      score_q    <= '0;
      key_prev_q <= '0;
    end else begin
      state_q    <= state_d;
      lives_q    <= lives_d;
      score_q    <= score_d;
      key_prev_q <= keycode;
    end
  end

  always_comb begin
    state_d      = state_q;
    lives_d      = lives_q;
    score_d      = score_q;
    tmr_load     = 1'b0;
    tmr_load_val = '0;
    tmr_en       = 1'b0;

    unique case (state_q)
      IDLE: begin
        if (launch) begin
          state_d      = SERVE;
          tmr_load     = 1'b1;
          tmr_load_val = 8'(SERVE_DELAY - 1);
        end
      end
      SERVE: begin
        if (tmr_zero) state_d = PLAY;
        else          tmr_en  = 1'b1;
      end
      PLAY: begin
        // Scoring is independent of the exit decision, so a hit on the leaving frame still counts.
        if (brick_hit) score_d = score_sum[16] ? '1 : score_sum[15:0];
        if (miss) begin
          state_d      = MISS;
          tmr_load     = 1'b1;
          tmr_load_val = 8'(MISS_HOLD - 1);
          if (lives_q != '0) lives_d = lives_q - 2'd1;
        end else if (bricks_left == '0) begin
          state_d = WIN;
        end
      end
      MISS: begin
        if (tmr_zero) begin
          if (lives_q == '0) begin
            state_d = OVER;
          end else begin
            state_d      = SERVE;
            tmr_load     = 1'b1;
            tmr_load_val = 8'(SERVE_DELAY - 1);
          end
        end else begin
          tmr_en = 1'b1;
        end
      end
      OVER, WIN: begin
        if (restart) begin
          state_d = IDLE;
          lives_d = 2'(LIVES_INIT);
          score_d = '0;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  assign ball_hold  = (state_q != PLAY);
  assign ball_run   = (state_q == PLAY);
  assign lives      = lives_q;
  assign score      = score_q;
  assign game_state = state_q;

endmodule

// File: tb/tb_breakout_game_ctrl.sv
// Directed + randomized bench for breakout_game_ctrl against a frame-level behavioural model.
module tb_breakout_game_ctrl;

  localparam int SD    = 60;
  localparam int MH    = 90;
  localparam int FLOOR = 479;
  localparam int PTS   = 10;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [7:0]  key;
  logic [9:0]  by, bs;
  logic        hit;
  logic [6:0]  bl;
  logic        hold, run;
  logic [1:0]  lives;
  logic [15:0] score;
  logic [2:0]  gs;

  int n_checks = 0;
  int n_errors = 0;

  // Model: state as a small integer, frames already spent in the timed state.
  int m_state, m_lives, m_score, m_spent, m_kprev;

  always #5 clk = ~clk;

  breakout_game_ctrl #(
    .LIVES_INIT  (3),
    .SERVE_DELAY (SD),
    .MISS_HOLD   (MH),
    .Y_FLOOR     (FLOOR),
    .PTS_BRICK   (PTS),
    .KEY_LAUNCH  (8'h2C),
    .KEY_RESTART (8'h15)
  ) dut (
    .frame_clk   (clk),
    .Reset_n     (rst_n),
    .keycode     (key),
    .BallY       (by),
    .BallS       (bs),
    .brick_hit   (hit),
    .bricks_left (bl),
    .ball_hold   (hold),
    .ball_run    (run),
    .lives       (lives),
    .score       (score),
    .game_state  (gs)
  );

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got=%0h expected=%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    bit launch, restart, miss;
    int nxt;
    if (!rst_n) begin
      m_state = 0; m_lives = 3; m_score = 0; m_spent = 0; m_kprev = 0;
      return;
    end
    launch  = (key == 8'h2C) && (m_kprev != 8'h2C);
    restart = (key == 8'h15) && (m_kprev != 8'h15);
    miss    = (int'(by) + int'(bs)) >= FLOOR;
    nxt = m_state;
    case (m_state)
      0: if (launch) begin nxt = 1; m_spent = 0; end
      1: if (m_spent == SD - 1) nxt = 2; else m_spent++;
      2: begin
        if (hit) m_score = (m_score + PTS > 65535) ? 65535 : m_score + PTS;
        if (miss) begin
          nxt = 3; m_spent = 0;
          if (m_lives > 0) m_lives--;
        end else if (bl == 0) nxt = 5;
      end
      3: begin
        if (m_spent == MH - 1) begin
          if (m_lives == 0) nxt = 4;
          else begin nxt = 1; m_spent = 0; end
        end else m_spent++;
      end
      default: if (restart) begin nxt = 0; m_lives = 3; m_score = 0; end
    endcase
    m_kprev = key;
    m_state = nxt;
  endtask

  task automatic tick();
    @(posedge clk);
    model_step();
    #1;
    check("state", 32'(gs), 32'(m_state));
    check("lives", 32'(lives), 32'(m_lives));
    check("score", 32'(score), 32'(m_score));
    check("hold", 32'(hold), 32'(m_state != 2));
    check("run", 32'(run), 32'(m_state == 2));
  endtask

  task automatic run_until(input string tag, input logic [2:0] target, input int budget);
    int n = 0;
    while ((gs != target) && (n < budget)) begin
      tick();
      n++;
    end
    check(tag, 32'(gs), 32'(target));
  endtask

  initial begin
    int serve_entries, frames;
    rst_n = 1'b0; key = '0; by = 10'd100; bs = 10'd4; hit = 1'b0; bl = 7'd50;

    // 1: reset
    tick(); tick();
    rst_n = 1'b1;
    tick();
    check("rst_state", 32'(gs), 0);
    check("rst_lives", 32'(lives), 3);
    check("rst_score", 32'(score), 0);
    check("rst_hold", 32'(hold), 1);
    check("rst_run", 32'(run), 0);

    // 2: held launch key fires once; release after exactly SD frames
    key = 8'h2C; serve_entries = 0; frames = 0;
    for (int i = 0; i < 5; i++) begin
      logic [2:0] prev;
      prev = gs;
      tick();
      if (i > 0) frames++;
      if (prev != 3'd1 && gs == 3'd1) serve_entries++;
    end
    check("serve_entries", 32'(serve_entries), 1);
    key = '0;
    while (!run && frames < 200) begin
      tick();
      frames++;
    end
    check("serve_len", 32'(frames), 32'(SD));

    // 3: miss boundary (475+4 = 479), hold, auto re-serve
    by = 10'd474; tick();
    check("no_miss_478", 32'(gs), 2);
    by = 10'd475; tick();
    check("miss_state", 32'(gs), 3);
    check("miss_lives", 32'(lives), 2);
    by = 10'd100;
    for (int i = 0; i < MH - 1; i++) tick();
    check("miss_hold_end", 32'(gs), 3);
    tick();
    check("reserve", 32'(gs), 1);
    for (int i = 0; i < SD - 1; i++) tick();
    check("reserve_end", 32'(gs), 1);
    tick();
    check("replay", 32'(gs), 2);

    // 4: two more misses -> OVER; launch ignored; restart
    by = 10'd475; tick(); by = 10'd100;
    run_until("play2", 3'd2, 400);
    by = 10'd475; tick(); by = 10'd100;
    run_until("over", 3'd4, 400);
    check("over_lives", 32'(lives), 0);
    key = 8'h2C; tick(); key = '0; tick();
    check("over_launch_ignored", 32'(gs), 4);
    key = 8'h15; tick(); key = '0;
    check("restart_state", 32'(gs), 0);
    check("restart_lives", 32'(lives), 3);

    // 5: scoring
    key = 8'h2C; tick(); key = '0;
    run_until("play3", 3'd2, 200);
    for (int i = 0; i < 4; i++) begin
      hit = 1'b1; tick(); hit = 1'b0; tick();
    end
    check("score40", 32'(score), 40);
    by = 10'd475; tick(); by = 10'd100;
    hit = 1'b1;
    run_until("play4", 3'd2, 400);
    hit = 1'b0;
    check("score_serve_ignored", 32'(score), 40);

    // 6: miss + hit + board clear in one frame -> MISS with points
    by = 10'd475; hit = 1'b1; bl = '0; tick();
    by = 10'd100; hit = 1'b0; bl = 7'd50;
    check("miss_beats_win", 32'(gs), 3);
    check("miss_frame_score", 32'(score), 50);
    run_until("play5", 3'd2, 400);
    bl = '0; tick(); bl = 7'd50;
    check("win", 32'(gs), 5);
    key = 8'h15; tick(); key = '0;
    key = 8'h2C; tick(); key = '0;
    run_until("play6", 3'd2, 200);

    // saturation: 6554 hits would reach 65540
    hit = 1'b1;
    for (int i = 0; i < 6553; i++) tick();
    check("score_65530", 32'(score), 65530);
    tick();
    check("score_sat", 32'(score), 32'hFFFF);
    tick();
    check("score_sat_hold", 32'(score), 32'hFFFF);
    hit = 1'b0;

    // reset mid-SERVE
    by = 10'd475; tick(); by = 10'd100;
    run_until("serve_again", 3'd1, 200);
    for (int i = 0; i < 10; i++) tick();
    rst_n = 1'b0; tick(); rst_n = 1'b1;
    check("rst_mid_serve", 32'(gs), 0);
    check("rst_mid_score", 32'(score), 0);

    // randomized phase
    for (int i = 0; i < 4000; i++) begin
      case ($urandom_range(0, 7))
        0, 1, 2: key = '0;
        3, 4:    key = 8'h2C;
        5:       key = 8'h15;
        default: key = 8'($urandom);
      endcase
      by    = ($urandom_range(0, 99) < 4) ? 10'($urandom_range(460, 1023)) : 10'($urandom_range(0, 470));
      bs    = 10'($urandom_range(0, 12));
      hit   = ($urandom_range(0, 3) == 0);
      bl    = ($urandom_range(0, 99) < 3) ? 7'd0 : 7'($urandom_range(1, 127));
      rst_n = ($urandom_range(0, 499) != 0);
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
